crossbar_port_arbiter: RTL

Packet-granular round-robin arbiter plus data multiplexer for one master port of the crossbar. Selects among `S_DATA_COUNT` slave-side sources whose destination equals this port's `PORT_ID`, locks the grant for a whole packet (until the `last` beat is transferred), and forwards the granted source's stream with full valid/ready backpressure. One instance sits in front of every master port.

---
 rtl/crossbar_pkg.sv | 30 +++
 rtl/rr_pick.sv | 42 ++++
 rtl/crossbar_port_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/crossbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_pkg
// Description : Shared types, width helper and default width constants for
//               the crossbar blocks (arbiters, pickers, muxes).
// Revision    : 1.0 - initial release
// ============================================================================
package crossbar_pkg;

    // Arbiter FSM: either searching for a winner or holding a packet grant.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Index width for n items; a single item still needs one bit of index.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default geometry shared by every crossbar block.
    localparam int c_T_DATA_WIDTH   = 8;
    localparam int c_S_DATA_COUNT   = 2;
    localparam int c_M_DATA_COUNT   = 3;
    localparam int c_T_ID___WIDTH   = clog2_min1(c_S_DATA_COUNT);
    localparam int c_T_DEST_WIDTH   = clog2_min1(c_M_DATA_COUNT);
    localparam int c_WDT_CYCLES     = 16;

endpackage : crossbar_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker. Searches req in the
//               order ptr+1, ptr+2, ... modulo N and returns the first set
//               index. Correct for any N, including non powers of two.
// Ports       : req   [N]  request vector
//               ptr   [W]  last winner (search starts just after it)
//               found      at least one request is set
//               idx   [W]  winning index (0 when nothing is found)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import crossbar_pkg::*;
#(
    parameter int N = 2,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Wrap with integer modulo so non power-of-two counts never alias.
    function automatic int f_wrap(input int p, input int k);
        return (p + k) % N;
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[f_wrap(int'(ptr), k)]) begin
                found = 1'b1;
                idx   = W'(f_wrap(int'(ptr), k));
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/crossbar_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_port_arbiter
// Description : Packet-granular round-robin arbiter and data mux for one
//               crossbar master port. Sources whose destination equals
//               PORT_ID compete; the winner keeps the grant until its last
//               beat transfers. Data/valid/ready/last pass combinationally
//               through the mux while LOCKED.
// Ports       : clk, rst            clock, async active-high reset
//               s_data_i/s_dest_i/s_valid_i/s_last_i  per-source stream in
//               s_ready_o           per-source ready (one-hot or zero)
//               m_data_o/m_last_o/m_valid_o/m_ready_i  forwarded stream
//               m_id_o              registered index of granted source
//               busy_o              high while a grant is held
//               wdt_drop_o          watchdog release pulse (macro only)
// Options     : CROSSBAR_ARB_WATCHDOG_EN - release a grant whose source has
//               been silent for WDT_CYCLES consecutive LOCKED cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module crossbar_port_arbiter
    import crossbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = c_S_DATA_COUNT,
    parameter  int M_DATA_COUNT = c_M_DATA_COUNT,
    parameter  int PORT_ID      = 0,
    parameter  int T_DATA_WIDTH = c_T_DATA_WIDTH,
    parameter  int WDT_CYCLES   = c_WDT_CYCLES,
    localparam int T_ID___WIDTH = clog2_min1(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = clog2_min1(M_DATA_COUNT)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]  s_data_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
    input  logic [S_DATA_COUNT-1:0]                    s_last_i,
    output logic [S_DATA_COUNT-1:0]                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                    m_data_o,
    output logic                                       m_last_o,
    output logic [T_ID___WIDTH-1:0]                    m_id_o,
    output logic                                       m_valid_o,
    input  logic                                       m_ready_i,
    output logic                                       busy_o
`ifdef CROSSBAR_ARB_WATCHDOG_EN
    ,
    output logic                                       wdt_drop_o
`endif
);

    localparam logic [T_DEST_WIDTH-1:0] c_PORT_DEST = T_DEST_WIDTH'(PORT_ID);
    localparam logic [T_ID___WIDTH-1:0] c_PTR_RESET = T_ID___WIDTH'(S_DATA_COUNT - 1);

    // Elaboration-time parameter sanity checks.
    if (S_DATA_COUNT < 1) begin : g_bad_s_count
        $error("crossbar_port_arbiter: S_DATA_COUNT must be at least 1");
    end
    if (PORT_ID < 0 || PORT_ID >= M_DATA_COUNT) begin : g_bad_port_id
        $error("crossbar_port_arbiter: PORT_ID out of range");
    end
    if (WDT_CYCLES < 1) begin : g_bad_wdt
        $error("crossbar_port_arbiter: WDT_CYCLES must be at least 1");
    end

    arb_state_t                r_state;
    logic [T_ID___WIDTH-1:0]   r_grant;
    logic [T_ID___WIDTH-1:0]   r_ptr;

    logic [S_DATA_COUNT-1:0]   w_req;
    logic                      w_found;
    logic [T_ID___WIDTH-1:0]   w_idx;
    logic                      w_last_xfer;

    // Only sources addressed to this port take part in arbitration.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            w_req[i] = s_valid_i[i] && (s_dest_i[i] == c_PORT_DEST);
        end
    end

    rr_pick #(
        .N (S_DATA_COUNT),
        .W (T_ID___WIDTH)
    ) u_rr_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // Zero-latency mux; everything is gated off outside LOCKED so a reset
    // mid-packet silences the port in the same cycle.
    always_comb begin
        m_data_o  = s_data_i[r_grant];
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        s_ready_o = '0;
        if (r_state == LOCKED) begin
            m_valid_o          = s_valid_i[r_grant];
            m_last_o           = s_last_i[r_grant];
            s_ready_o[r_grant] = m_ready_i;
        end
    end

    assign w_last_xfer = m_valid_o && m_ready_i && m_last_o;
    assign busy_o      = (r_state == LOCKED);
    assign m_id_o      = r_grant;

`ifdef CROSSBAR_ARB_WATCHDOG_EN
    localparam int c_WDT_WIDTH = $clog2(WDT_CYCLES + 1);

    logic [c_WDT_WIDTH-1:0] r_wdt_cnt;
    logic                   r_wdt_drop;

    assign wdt_drop_o = r_wdt_drop;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= c_PTR_RESET;
`ifdef CROSSBAR_ARB_WATCHDOG_EN
            r_wdt_cnt  <= '0;
            r_wdt_drop <= 1'b0;
`endif
        end else begin
`ifdef CROSSBAR_ARB_WATCHDOG_EN
            r_wdt_drop <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_idx;
                        r_ptr     <= w_idx;
                        r_state   <= LOCKED;
`ifdef CROSSBAR_ARB_WATCHDOG_EN
                        r_wdt_cnt <= '0;
`endif
                    end
                end
                LOCKED: begin
                    if (w_last_xfer) begin
                        r_state <= IDLE;
                    end
`ifdef CROSSBAR_ARB_WATCHDOG_EN
                    // Stalls with the source valid are not silence; only
                    // consecutive invalid cycles count toward a drop. The
                    // pointer is left on the dropped source so it ranks last.
                    if (s_valid_i[r_grant]) begin
                        r_wdt_cnt <= '0;
                    end else if (r_wdt_cnt == c_WDT_WIDTH'(WDT_CYCLES - 1)) begin
                        r_wdt_cnt  <= '0;
                        r_wdt_drop <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_wdt_cnt <= r_wdt_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : crossbar_port_arbiter
`default_nettype wire
